// File: rtl/usb_buffer_arbiter.sv
// rtl/usb_buffer_arbiter.sv - scheduler for the shared single-port USB data buffer (optional USB_BUF_RR_EN: TX/AHB round-robin)

module usb_buffer_arbiter #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_store,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_flush,
  input  logic              tx_get,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              ahb_push,
  input  logic [DATA_W-1:0] ahb_wdata,
  input  logic              ahb_pop,
  output logic [DATA_W-1:0] ahb_rdata,
  output logic              ahb_grant,
  input  logic              ahb_clear,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   buffer_occupancy,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WR         = 3'd1;
  localparam logic [2:0] S_RD_ISSUE   = 3'd2;
  localparam logic [2:0] S_RD_CAPTURE = 3'd3;
  localparam logic [2:0] S_RD_EMPTY   = 3'd4;

  localparam logic [ADDR_W:0]   OCC_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   OCC_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [2:0]        state_q, state_d;
  logic              owner_ahb_q, owner_ahb_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   occ_q, occ_d;
  logic              rx_pend_q, rx_pend_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              tx_pend_q, tx_pend_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] ahb_rdata_q, ahb_rdata_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
`ifdef USB_BUF_RR_EN
  logic              last_ahb_q, last_ahb_d;
`endif

  logic              flush;
  logic              full;
  logic              empty;
  logic              ahb_req;
  logic              pick_ahb;
  logic              rx_done;
  logic              tx_done;
  logic [DATA_W-1:0] cap_byte;

  assign flush   = rx_flush | ahb_clear;
  assign full    = (occ_q == OCC_FULL);
  assign empty   = (occ_q == '0);
  assign ahb_req = ahb_push | ahb_pop;

  // An empty-buffer read never touches the memory, so its result is a fixed zero byte
  assign cap_byte = (state_q == S_RD_EMPTY) ? '0 : mem_rdata;

  // Choose between TX and AHB when RX has nothing pending
  always_comb begin
`ifdef USB_BUF_RR_EN
    if (tx_pend_q && ahb_req) begin
      pick_ahb = ~last_ahb_q;
    end else begin
      pick_ahb = ahb_req;
    end
`else
    pick_ahb = ~tx_pend_q & ahb_req;
`endif
  end

  // Buffer port sequencing, pointer/occupancy bookkeeping, pending latches and error flags
  always_comb begin
    state_d     = state_q;
    owner_ahb_d = owner_ahb_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    rx_pend_d   = rx_pend_q;
    rx_data_d   = rx_data_q;
    tx_pend_d   = tx_pend_q;
    tx_data_d   = tx_data_q;
    ahb_rdata_d = ahb_rdata_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
`ifdef USB_BUF_RR_EN
    last_ahb_d  = last_ahb_q;
`endif
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = rd_ptr_q;
    mem_wdata   = owner_ahb_q ? ahb_wdata : rx_data_q;
    tx_valid    = 1'b0;
    ahb_grant   = 1'b0;
    rx_done     = 1'b0;
    tx_done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_pend_q) begin
          owner_ahb_d = 1'b0;
          state_d     = S_WR;
        end else if (tx_pend_q || ahb_req) begin
          owner_ahb_d = pick_ahb;
`ifdef USB_BUF_RR_EN
          last_ahb_d  = pick_ahb;
`endif
          if (pick_ahb && ahb_push) begin
            state_d = S_WR;
          end else begin
            state_d = empty ? S_RD_EMPTY : S_RD_ISSUE;
          end
        end
      end

      S_WR: begin
        mem_addr = wr_ptr_q;
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          occ_d    = occ_q + OCC_ONE;
        end
        if (owner_ahb_q) begin
          ahb_grant = 1'b1;
        end else begin
          rx_done = 1'b1;
        end
        state_d = S_IDLE;
      end

      S_RD_ISSUE: begin
        mem_re   = 1'b1;
        mem_addr = rd_ptr_q;
        state_d  = S_RD_CAPTURE;
      end

      S_RD_CAPTURE, S_RD_EMPTY: begin
        if (state_q == S_RD_CAPTURE) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          occ_d    = occ_q - OCC_ONE;
        end else begin
          unf_d = 1'b1;
        end
        if (owner_ahb_q) begin
          ahb_grant   = 1'b1;
          ahb_rdata_d = cap_byte;
        end else begin
          tx_valid  = 1'b1;
          tx_done   = 1'b1;
          tx_data_d = cap_byte;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (rx_done) begin
      rx_pend_d = 1'b0;
    end
    if (tx_done) begin
      tx_pend_d = 1'b0;
    end
    if (tx_get) begin
      tx_pend_d = 1'b1;
    end

    // The single RX holding register cannot queue a second byte; the newer store is lost
    if (rx_store) begin
      if (rx_pend_q && !rx_done) begin
        ovf_d = 1'b1;
      end else begin
        rx_pend_d = 1'b1;
        rx_data_d = rx_data;
      end
    end

    // Flush/clear aborts whatever the port was doing and discards any same-cycle store
    if (flush) begin
      state_d     = S_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      tx_pend_d   = 1'b0;
      rx_pend_d   = rx_pend_q;
      rx_data_d   = rx_data_q;
      tx_data_d   = tx_data_q;
      ahb_rdata_d = ahb_rdata_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
`ifdef USB_BUF_RR_EN
      last_ahb_d  = last_ahb_q;
`endif
      mem_we      = 1'b0;
      tx_valid    = 1'b0;
      ahb_grant   = 1'b0;
      if (ahb_clear) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_ahb_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      rx_pend_q   <= 1'b0;
      rx_data_q   <= '0;
      tx_pend_q   <= 1'b0;
      tx_data_q   <= '0;
      ahb_rdata_q <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
`ifdef USB_BUF_RR_EN
      last_ahb_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_ahb_q <= owner_ahb_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      rx_pend_q   <= rx_pend_d;
      rx_data_q   <= rx_data_d;
      tx_pend_q   <= tx_pend_d;
      tx_data_q   <= tx_data_d;
      ahb_rdata_q <= ahb_rdata_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
`ifdef USB_BUF_RR_EN
      last_ahb_q  <= last_ahb_d;
`endif
    end
  end

  // The fetched byte is forwarded during its valid/grant pulse and held afterwards
  assign tx_data          = tx_valid ? cap_byte : tx_data_q;
  assign ahb_rdata        = ahb_grant ? cap_byte : ahb_rdata_q;
  assign buffer_occupancy = occ_q;
  assign overflow_err     = ovf_q;
  assign underflow_err    = unf_q;

endmodule

// File: doc/usb_buffer_arbiter.md
Name: usb_buffer_arbiter

Overview:
- Owns the single-port 64x8 data buffer shared by the USB RX path, the USB TX path and the AHB slave.
- Latches byte-level requests from each requester and schedules them onto the buffer memory port.
- Maintains the circular read/write pointers and the occupancy count.
- RX stores get absolute priority because they cannot be stalled at line rate; TX fetches and AHB accesses are serialised behind them.

Parameters:
DEPTH, 64, buffer entries; must be a power of 2
ADDR_W, 6, log2(DEPTH)
DATA_W, 8, byte width

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
rx_store  in  1  store pulse from RX path
rx_data  in  DATA_W  byte to store
rx_flush  in  1  flush pulse from RX path
tx_get  in  1  TX fetch pulse
tx_data  out  DATA_W  fetched byte, valid with tx_valid
tx_valid  out  1  1-cycle pulse, fetch done
ahb_push  in  1  AHB write request; held until ahb_grant
ahb_wdata  in  DATA_W  AHB write byte
ahb_pop  in  1  AHB read request; held until ahb_grant
ahb_rdata  out  DATA_W  AHB read byte, valid with ahb_grant on a pop
ahb_grant  out  1  1-cycle pulse, AHB request done
ahb_clear  in  1  AHB buffer clear pulse
mem_addr  out  ADDR_W  buffer address
mem_we  out  1  buffer write strobe
mem_wdata  out  DATA_W  buffer write data
mem_re  out  1  buffer read strobe; data returns on mem_rdata the next cycle
mem_rdata  in  DATA_W  buffer read data
buffer_occupancy  out  ADDR_W+1  bytes held, 0..DEPTH
overflow_err  out  1  sticky: write when full, or RX store while RX pending
underflow_err  out  1  sticky: read when empty

Behaviour:
- Reset (rst sampled high at clk edge):
  - Pointers, occupancy, pending bits, tx_data and ahb_rdata are 0.
  - All pulses and error flags are 0; FSM goes to IDLE.
- Pending latches:
  - rx_pend is set by rx_store, which also captures rx_data.
  - tx_pend is set by tx_get.
  - AHB requests are level-held and do not latch.
  - rx_store while rx_pend is already set: the store is dropped and overflow_err is set.
- FSM states:
  - IDLE: grant priority is rx_pend > tx_pend > ahb_push > ahb_pop.
    - rx_pend or ahb_push goes to WR.
    - tx_pend or ahb_pop goes to RD_ISSUE.
  - WR, one cycle: mem_we=1, mem_addr=wr_ptr. Then wr_ptr+1 (mod DEPTH), occupancy+1, clear the owner's pending bit or pulse ahb_grant. Return to IDLE.
  - RD_ISSUE: mem_re=1, mem_addr=rd_ptr. Go to RD_CAPTURE.
  - RD_CAPTURE: latch mem_rdata into tx_data or ahb_rdata. Pulse tx_valid or ahb_grant. rd_ptr+1, occupancy-1. Return to IDLE.
- Full boundary: a granted write with occupancy==DEPTH does no mem_we, leaves occupancy unchanged, sets overflow_err, and still clears pending / pulses the grant.
- Empty boundary: a granted read with occupancy==0 does no mem_re and takes one cycle. The returned byte is 0x00, the valid/grant pulse still fires, and underflow_err is set.
- RX latency: a store is written within 4 cycles of rx_store in the worst case (arrives just after a read issue).
- Flush and clear:
  - rx_flush or ahb_clear zeroes the pointers, occupancy and tx_pend, and returns the FSM to IDLE next cycle. An in-flight read is aborted with no pulse.
  - Flush wins over a same-cycle rx_store; that store is discarded.
  - ahb_clear additionally clears both error flags. rx_flush leaves the error flags unchanged.
- Pointer arithmetic: pointers are ADDR_W bits and wrap naturally.
- buffer_occupancy is registered and updated in the WR and RD_CAPTURE cycles.
- Simultaneous events: a same-cycle push and pop from the AHB side is illegal; the AHB side never issues it.

Optional Feature:
- Macro: USB_BUF_RR_EN.
- Defined: round-robin between tx_pend and the AHB requests, with last-served toggling on each grant. RX keeps absolute priority.
- Undefined: fixed priority as in Behaviour; the AHB side can starve while tx_pend is repeatedly asserted.

Test Plan:
- Reset then 3 rx_store pulses with bytes 0xA5, 0x3C, 0xFF -> mem writes at addresses 0,1,2; buffer_occupancy=3; each write within 4 cycles of its store.
- 3 ahb_pop after the above -> ahb_rdata 0xA5, 0x3C, 0xFF, one per ahb_grant; occupancy=0; underflow_err=0.
- 64 ahb_push of 0x00..0x3F then a 65th push -> occupancy=64, overflow_err=1. The 65th push gets no mem_we but still gets ahb_grant. Then 64 tx_get -> tx_data 0x00..0x3F with rd_ptr wrap.
- rx_store and tx_get in the same cycle, occupancy=1 -> WR is served first, then the read. tx_valid comes 3 cycles after WR and returns the old head byte.
- rx_flush in the same cycle as rx_store at occupancy 5 -> occupancy=0, no mem_we, error flags unchanged. ahb_clear then clears a previously set underflow_err.
- ahb_pop on an empty buffer -> ahb_grant one cycle after IDLE, ahb_rdata=0x00, underflow_err=1. Under USB_BUF_RR_EN: continuous tx_get plus a held ahb_push -> grants alternate TX/AHB.
